// File: rtl/sram_read_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_read_ctl_pkg
//  Brief    : Shared encodings for the SRAM read controller: top FSM states,
//             local scan FSM, bank-to-quadrant permutation and data widths.
//  Revision : 1.0  initial release
// ============================================================================
package sram_read_ctl_pkg;

    localparam int c_CH_NUM       = 24;
    localparam int c_ACT_PER_ADDR = 4;
    localparam int c_BW_PER_ACT   = 16;
    localparam int c_ADDR_W       = 16;
    localparam int c_MAP_W        = 2;
    localparam int c_IDX_W        = 7;
    localparam int c_DELAY        = 5;

    // Top-level FSM encoding, shared with the write controller
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PADDING = 4'd1,
        ST_CONV1   = 4'd2,
        ST_RES_1   = 4'd3,
        ST_RES_2   = 4'd4,
        ST_UP_1    = 4'd5,
        ST_UP_2    = 4'd6,
        ST_CONV2   = 4'd7,
        ST_FINISH  = 4'd8
    } top_state_t;

    // Local scan FSM
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_fsm_t;

    // Window quadrants; bank index is {row parity, col parity}
    localparam logic [1:0] c_Q_LU = 2'd0;
    localparam logic [1:0] c_Q_RU = 2'd1;
    localparam logic [1:0] c_Q_LD = 2'd2;
    localparam logic [1:0] c_Q_RD = 2'd3;

    // Bank holding a given quadrant: the window origin parity flips the
    // row/column parity of every quadrant, which is an XOR on the index.
    function automatic logic [1:0] quad_bank(input logic [1:0] quad, input logic [1:0] mt);
        return quad ^ mt;
    endfunction

    // States that own a read scan
    function automatic logic is_scan_state(input logic [3:0] st);
        logic ok;
        ok = 1'b0;
        case (st)
            ST_CONV1, ST_RES_1, ST_RES_2, ST_UP_1, ST_UP_2, ST_CONV2: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // States whose source map lives in SRAM B
    function automatic logic reads_sram_b(input logic [3:0] st);
        return (st == ST_RES_1) || (st == ST_UP_1) || (st == ST_CONV2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tag_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : tag_delay_line
//  Brief    : Fixed-depth shift register carrying a valid bit and a tag word.
//             Every stage shifts every cycle, so bubbles travel with the data.
//  Revision : 1.0  initial release
// ============================================================================
module tag_delay_line #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0]            r_vld;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;

    generate
        if (DEPTH == 1) begin : g_single
            // Single register stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld  <= '0;
                    r_data <= '0;
                end else begin
                    r_vld[0]  <= i_valid;
                    r_data[0] <= i_data;
                end
            end
        end else begin : g_chain
            // Shift chain: stage 0 takes the input, last stage drives the output
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld  <= '0;
                    r_data <= '0;
                end else begin
                    r_vld  <= {r_vld[DEPTH-2:0], i_valid};
                    r_data <= {r_data[DEPTH-2:0], i_data};
                end
            end
        end
    endgenerate

    assign o_valid = r_vld[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sram_read_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_read_ctl
//  Brief    : Scans the feature map in 2x2-tile windows, issues one read per
//             cycle to four interleaved SRAM banks (A or B), reassembles the
//             returned tiles into LU/RU/LD/RD order and emits a 5-cycle
//             delayed address/tag stream for the write controller.
//             Optional feature macro: SRAM_RD_UPSAMPLE_EN (4 sub-pixel
//             phases per channel in UP_1/UP_2).
//  Revision : 1.0  initial release
// ============================================================================
module sram_read_ctl
    import sram_read_ctl_pkg::*;
#(
    parameter int CH_NUM       = c_CH_NUM,
    parameter int ACT_PER_ADDR = c_ACT_PER_ADDR,
    parameter int BW_PER_ACT   = c_BW_PER_ACT,
    parameter int TILE_W       = 42,
    parameter int TILE_H       = 42,
    parameter int BANK_PITCH   = 21
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [3:0]                                 state,
    input  logic                                       start,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_a0,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_a1,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_a2,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_a3,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_b0,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_b1,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_b2,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_b3,
    output logic [15:0]                                sram_raddr_0,
    output logic [15:0]                                sram_raddr_1,
    output logic [15:0]                                sram_raddr_2,
    output logic [15:0]                                sram_raddr_3,
    output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  window_LU,
    output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  window_RU,
    output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  window_LD,
    output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  window_RD,
    output logic                                       window_valid,
    output logic [1:0]                                 map_type,
    output logic [6:0]                                 fmap_idx,
    output logic [15:0]                                read_addr0_delay5,
    output logic [15:0]                                read_addr1_delay5,
    output logic [15:0]                                read_addr2_delay5,
    output logic [15:0]                                read_addr3_delay5,
    output logic [1:0]                                 map_type_delay5,
    output logic [6:0]                                 fmap_idx_delay5,
    output logic                                       output_en,
    output logic                                       busy,
    output logic                                       done
);

    localparam int          c_DW      = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
    localparam int          c_TAG_W   = 4 * c_ADDR_W + c_MAP_W + c_IDX_W + 1;
    localparam logic [15:0] c_TR_LAST = 16'(TILE_H - 2);
    localparam logic [15:0] c_TC_LAST = 16'(TILE_W - 2);
    localparam logic [15:0] c_PITCH   = 16'(BANK_PITCH);
    localparam logic [6:0]  c_K_BASE  = 7'(CH_NUM);
`ifdef SRAM_RD_UPSAMPLE_EN
    localparam logic [6:0]  c_K_UP    = 7'(4 * CH_NUM);
`endif

    rd_fsm_t            r_fsm;
    rd_fsm_t            w_fsm_nxt;
    logic [15:0]        r_tr;
    logic [15:0]        r_tc;
    logic [6:0]         r_k;
    logic [6:0]         r_k_last;
    logic [6:0]         w_k_last_sel;
    logic               r_src_b;
    logic               w_start_ok;
    logic               w_last_issue;

    logic [15:0]        w_row_even;
    logic [15:0]        w_row_odd;
    logic [15:0]        w_col_even;
    logic [15:0]        w_col_odd;
    logic [15:0]        w_addr  [4];
    logic [15:0]        r_raddr [4];
    logic               r_iss_vld;
    logic               r_iss_last;
    logic [1:0]         r_iss_mt;
    logic [6:0]         r_iss_k;

    logic               r_ret_vld;
    logic [1:0]         r_ret_mt;
    logic [6:0]         r_ret_k;
    logic [c_DW-1:0]    w_bank [4];

    logic [c_DW-1:0]    r_win_lu;
    logic [c_DW-1:0]    r_win_ru;
    logic [c_DW-1:0]    r_win_ld;
    logic [c_DW-1:0]    r_win_rd;
    logic               r_win_vld;
    logic [1:0]         r_map_type;
    logic [6:0]         r_fmap_idx;

    logic               w_dl_vld;
    logic [c_TAG_W-1:0] w_dl_data;
    logic               w_dl_last;
    logic               r_done;

    assign w_start_ok   = (r_fsm == RD_IDLE) && start && is_scan_state(state);
    assign w_last_issue = (r_fsm == RD_RUN) && (r_k == r_k_last) &&
                          (r_tc == c_TC_LAST) && (r_tr == c_TR_LAST);

    // Channel count for the scan about to start
    always_comb begin
        w_k_last_sel = c_K_BASE - 7'd1;
`ifdef SRAM_RD_UPSAMPLE_EN
        if ((state == ST_UP_1) || (state == ST_UP_2)) begin
            w_k_last_sel = c_K_UP - 7'd1;
        end
`endif
    end

    // Scan FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= RD_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Scan FSM next state; DRAIN ends on the final delayed issue
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            RD_IDLE:  if (w_start_ok)              w_fsm_nxt = RD_RUN;
            RD_RUN:   if (w_last_issue)            w_fsm_nxt = RD_DRAIN;
            RD_DRAIN: if (w_dl_vld && w_dl_last)   w_fsm_nxt = RD_IDLE;
            default:                               w_fsm_nxt = RD_IDLE;
        endcase
    end

    // Window counters (k innermost) plus source/K latched at start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tr     <= '0;
            r_tc     <= '0;
            r_k      <= '0;
            r_k_last <= '0;
            r_src_b  <= 1'b0;
        end else if (w_start_ok) begin
            r_tr     <= '0;
            r_tc     <= '0;
            r_k      <= '0;
            r_k_last <= w_k_last_sel;
            r_src_b  <= reads_sram_b(state);
        end else if (r_fsm == RD_RUN) begin
            if (r_k == r_k_last) begin
                r_k <= '0;
                if (r_tc == c_TC_LAST) begin
                    r_tc <= '0;
                    r_tr <= r_tr + 16'd1;
                end else begin
                    r_tc <= r_tc + 16'd1;
                end
            end else begin
                r_k <= r_k + 7'd1;
            end
        end
    end

    // Per-bank addresses: each bank sees the window row/col of its parity
    always_comb begin
        w_row_even = r_tr[0] ? 16'(r_tr + 16'd1) : r_tr;
        w_row_odd  = r_tr[0] ? r_tr : 16'(r_tr + 16'd1);
        w_col_even = r_tc[0] ? 16'(r_tc + 16'd1) : r_tc;
        w_col_odd  = r_tc[0] ? r_tc : 16'(r_tc + 16'd1);
        w_addr[0]  = 16'((w_row_even >> 1) * c_PITCH + (w_col_even >> 1));
        w_addr[1]  = 16'((w_row_even >> 1) * c_PITCH + (w_col_odd  >> 1));
        w_addr[2]  = 16'((w_row_odd  >> 1) * c_PITCH + (w_col_even >> 1));
        w_addr[3]  = 16'((w_row_odd  >> 1) * c_PITCH + (w_col_odd  >> 1));
    end

    // Issue stage: addresses and tags registered, valid during the issue cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raddr    <= '{default: '0};
            r_iss_vld  <= 1'b0;
            r_iss_last <= 1'b0;
            r_iss_mt   <= '0;
            r_iss_k    <= '0;
        end else begin
            r_iss_vld  <= (r_fsm == RD_RUN);
            r_iss_last <= w_last_issue;
            if (r_fsm == RD_RUN) begin
                r_raddr  <= w_addr;
                r_iss_mt <= {r_tr[0], r_tc[0]};
                r_iss_k  <= r_k;
            end
        end
    end

    // Tags follow the SRAM read latency so they meet the returned data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ret_vld <= 1'b0;
            r_ret_mt  <= '0;
            r_ret_k   <= '0;
        end else begin
            r_ret_vld <= r_iss_vld;
            r_ret_mt  <= r_iss_mt;
            r_ret_k   <= r_iss_k;
        end
    end

    // Source SRAM selection
    always_comb begin
        w_bank[0] = r_src_b ? sram_rdata_b0 : sram_rdata_a0;
        w_bank[1] = r_src_b ? sram_rdata_b1 : sram_rdata_a1;
        w_bank[2] = r_src_b ? sram_rdata_b2 : sram_rdata_a2;
        w_bank[3] = r_src_b ? sram_rdata_b3 : sram_rdata_a3;
    end

    // Window registers: permute banks into quadrants by origin parity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_lu   <= '0;
            r_win_ru   <= '0;
            r_win_ld   <= '0;
            r_win_rd   <= '0;
            r_win_vld  <= 1'b0;
            r_map_type <= '0;
            r_fmap_idx <= '0;
        end else begin
            r_win_vld <= r_ret_vld;
            if (r_ret_vld) begin
                r_win_lu   <= w_bank[quad_bank(c_Q_LU, r_ret_mt)];
                r_win_ru   <= w_bank[quad_bank(c_Q_RU, r_ret_mt)];
                r_win_ld   <= w_bank[quad_bank(c_Q_LD, r_ret_mt)];
                r_win_rd   <= w_bank[quad_bank(c_Q_RD, r_ret_mt)];
                r_map_type <= r_ret_mt;
                r_fmap_idx <= r_ret_k;
            end
        end
    end

    tag_delay_line #(
        .DEPTH (c_DELAY),
        .WIDTH (c_TAG_W)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_iss_vld),
        .i_data  ({r_raddr[0], r_raddr[1], r_raddr[2], r_raddr[3],
                   r_iss_mt, r_iss_k, r_iss_last}),
        .o_valid (w_dl_vld),
        .o_data  (w_dl_data)
    );

    // Completion pulse the cycle after the last delayed issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_fsm == RD_DRAIN) && w_dl_vld && w_dl_last;
        end
    end

    assign {read_addr0_delay5, read_addr1_delay5, read_addr2_delay5,
            read_addr3_delay5, map_type_delay5, fmap_idx_delay5,
            w_dl_last} = w_dl_data;
    assign output_en    = w_dl_vld;

    assign sram_raddr_0 = r_raddr[0];
    assign sram_raddr_1 = r_raddr[1];
    assign sram_raddr_2 = r_raddr[2];
    assign sram_raddr_3 = r_raddr[3];
    assign window_LU    = r_win_lu;
    assign window_RU    = r_win_ru;
    assign window_LD    = r_win_ld;
    assign window_RD    = r_win_rd;
    assign window_valid = r_win_vld;
    assign map_type     = r_map_type;
    assign fmap_idx     = r_fmap_idx;
    assign busy         = (r_fsm != RD_IDLE);
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sram_read_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_read_ctl
//  Brief    : Scoreboard bench for sram_read_ctl on a 4x4-tile map: the
//             driver pushes expected windows and delayed tags at each start,
//             a negedge monitor pops and compares on window_valid/output_en.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sram_read_ctl;
    import sram_read_ctl_pkg::*;

    localparam int DW = 1536;
    localparam int TW = 4;
    localparam int TH = 4;
    localparam int BP = 2;
`ifdef SRAM_RD_UPSAMPLE_EN
    localparam int K_UP = 96;
`else
    localparam int K_UP = 24;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    state;
    logic          start;
    logic [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic [15:0]   sram_raddr_0, sram_raddr_1, sram_raddr_2, sram_raddr_3;
    logic [DW-1:0] window_LU, window_RU, window_LD, window_RD;
    logic          window_valid;
    logic [1:0]    map_type, map_type_delay5;
    logic [6:0]    fmap_idx, fmap_idx_delay5;
    logic [15:0]   read_addr0_delay5, read_addr1_delay5, read_addr2_delay5, read_addr3_delay5;
    logic          output_en, busy, done;

    sram_read_ctl #(.TILE_W(TW), .TILE_H(TH), .BANK_PITCH(BP)) dut (
        .clk(clk), .rst(rst), .state(state), .start(start),
        .sram_rdata_a0(a0), .sram_rdata_a1(a1), .sram_rdata_a2(a2), .sram_rdata_a3(a3),
        .sram_rdata_b0(b0), .sram_rdata_b1(b1), .sram_rdata_b2(b2), .sram_rdata_b3(b3),
        .sram_raddr_0(sram_raddr_0), .sram_raddr_1(sram_raddr_1),
        .sram_raddr_2(sram_raddr_2), .sram_raddr_3(sram_raddr_3),
        .window_LU(window_LU), .window_RU(window_RU), .window_LD(window_LD), .window_RD(window_RD),
        .window_valid(window_valid), .map_type(map_type), .fmap_idx(fmap_idx),
        .read_addr0_delay5(read_addr0_delay5), .read_addr1_delay5(read_addr1_delay5),
        .read_addr2_delay5(read_addr2_delay5), .read_addr3_delay5(read_addr3_delay5),
        .map_type_delay5(map_type_delay5), .fmap_idx_delay5(fmap_idx_delay5),
        .output_en(output_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]    mt;
        logic [6:0]    idx;
        logic [DW-1:0] lu, ru, ld, rd;
    } win_t;
    typedef struct {
        logic [15:0] a0, a1, a2, a3;
        logic [1:0]  mt;
        logic [6:0]  idx;
    } tag_t;

    win_t win_q[$];
    tag_t tag_q[$];

    int start_cyc, oe_first, oe_last, oe_cnt, wv_first, wv_cnt, done_cnt, done_cyc;
    logic [63:0] hist [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual[63:0]=%h required[63:0]=%h (t=%0t)", name, act[63:0], exp[63:0], $time);
        end
    endtask

    // Tile contents: source letter, bank, address replicated over the word
    function automatic logic [DW-1:0] pat(input logic sb, input logic [1:0] bank, input logic [15:0] addr);
        logic [15:0] w;
        w = {(sb ? 4'hB : 4'hA), bank, addr[9:0]};
        return {96{w}};
    endfunction

    // Synchronous-read SRAM model: address in cycle t, data in t+1
    always @(posedge clk) begin
        a0 <= pat(1'b0, 2'd0, sram_raddr_0);
        a1 <= pat(1'b0, 2'd1, sram_raddr_1);
        a2 <= pat(1'b0, 2'd2, sram_raddr_2);
        a3 <= pat(1'b0, 2'd3, sram_raddr_3);
        b0 <= pat(1'b1, 2'd0, sram_raddr_0);
        b1 <= pat(1'b1, 2'd1, sram_raddr_1);
        b2 <= pat(1'b1, 2'd2, sram_raddr_2);
        b3 <= pat(1'b1, 2'd3, sram_raddr_3);
    end

    // Expected stream for one scan, straight from the address/quadrant rules
    task automatic push_scan(input logic sb, input int kk);
        int re, ro, ce, co;
        logic [15:0] ad [4];
        logic [1:0] mt;
        int ql, qr, qd, qx;
        tag_t t;
        win_t w;
        for (int tr = 0; tr <= TH - 2; tr++) begin
            for (int tc = 0; tc <= TW - 2; tc++) begin
                re = (tr % 2 == 0) ? tr : tr + 1;
                ro = (tr % 2 == 1) ? tr : tr + 1;
                ce = (tc % 2 == 0) ? tc : tc + 1;
                co = (tc % 2 == 1) ? tc : tc + 1;
                ad[0] = 16'((re / 2) * BP + ce / 2);
                ad[1] = 16'((re / 2) * BP + co / 2);
                ad[2] = 16'((ro / 2) * BP + ce / 2);
                ad[3] = 16'((ro / 2) * BP + co / 2);
                mt = 2'((tr % 2) * 2 + (tc % 2));
                case (mt)
                    2'd0:    begin ql = 0; qr = 1; qd = 2; qx = 3; end
                    2'd1:    begin ql = 1; qr = 0; qd = 3; qx = 2; end
                    2'd2:    begin ql = 2; qr = 3; qd = 0; qx = 1; end
                    default: begin ql = 3; qr = 2; qd = 1; qx = 0; end
                endcase
                for (int k = 0; k < kk; k++) begin
                    t.a0 = ad[0]; t.a1 = ad[1]; t.a2 = ad[2]; t.a3 = ad[3];
                    t.mt = mt; t.idx = 7'(k);
                    tag_q.push_back(t);
                    w.mt = mt; w.idx = 7'(k);
                    w.lu = pat(sb, 2'(ql), ad[ql]);
                    w.ru = pat(sb, 2'(qr), ad[qr]);
                    w.ld = pat(sb, 2'(qd), ad[qd]);
                    w.rd = pat(sb, 2'(qx), ad[qx]);
                    win_q.push_back(w);
                end
            end
        end
    endtask

    task automatic clear_stats();
        oe_first = -1; oe_last = -1; oe_cnt = 0;
        wv_first = -1; wv_cnt = 0; done_cnt = 0; done_cyc = -1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output
    always @(negedge clk) begin
        win_t w;
        tag_t t;
        for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {sram_raddr_0, sram_raddr_1, sram_raddr_2, sram_raddr_3};
        if (window_valid) begin
            if (wv_first < 0) wv_first = cyc;
            wv_cnt++;
            if (win_q.size() == 0) begin
                chk("window_valid_unexpected", 64'(window_valid), 64'd0);
            end else begin
                w = win_q.pop_front();
                chk_wide("window_LU", window_LU, w.lu);
                chk_wide("window_RU", window_RU, w.ru);
                chk_wide("window_LD", window_LD, w.ld);
                chk_wide("window_RD", window_RD, w.rd);
                chk("map_type", 64'(map_type), 64'(w.mt));
                chk("fmap_idx", 64'(fmap_idx), 64'(w.idx));
            end
        end
        if (output_en) begin
            if (oe_first < 0) oe_first = cyc;
            oe_last = cyc;
            oe_cnt++;
            if (tag_q.size() == 0) begin
                chk("output_en_unexpected", 64'(output_en), 64'd0);
            end else begin
                t = tag_q.pop_front();
                chk("read_addr0_delay5", 64'(read_addr0_delay5), 64'(t.a0));
                chk("read_addr1_delay5", 64'(read_addr1_delay5), 64'(t.a1));
                chk("read_addr2_delay5", 64'(read_addr2_delay5), 64'(t.a2));
                chk("read_addr3_delay5", 64'(read_addr3_delay5), 64'(t.a3));
                chk("map_type_delay5", 64'(map_type_delay5), 64'(t.mt));
                chk("fmap_idx_delay5", 64'(fmap_idx_delay5), 64'(t.idx));
                chk("issue_raddrs", hist[5], {t.a0, t.a1, t.a2, t.a3});
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic run_scan(input logic [3:0] st, input logic sb, input int kk, input bit poke);
        int n, budget;
        n = 9 * kk;
        clear_stats();
        push_scan(sb, kk);
        @(posedge clk); #2;
        state = st; start = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        #1 start = 1'b0;
        if (poke) begin
            // start mid-RUN with a different state, then change state: both ignored
            repeat (40) @(posedge clk);
            #2 state = ST_CONV2; start = 1'b1;
            @(negedge clk);
            chk("busy_after_run_start", 64'(busy), 64'd1);
            @(posedge clk); #2 start = 1'b0; state = ST_RES_1;
            @(negedge clk);
            chk("busy_after_state_change", 64'(busy), 64'd1);
        end
        budget = 0;
        while (done_cnt == 0 && budget < n + 60) begin
            @(posedge clk);
            budget++;
        end
        chk("done_seen", 64'(done_cnt > 0), 64'd1);
        repeat (3) @(negedge clk);
        chk("first_output_en_latency", 64'(oe_first - start_cyc), 64'd6);
        chk("first_window_latency", 64'(wv_first - start_cyc), 64'd3);
        chk("output_en_count", 64'(oe_cnt), 64'(n));
        chk("output_en_contiguous", 64'(oe_last - oe_first + 1), 64'(n));
        chk("window_count", 64'(wv_cnt), 64'(n));
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("done_after_last_oe", 64'(done_cyc - oe_last), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("win_queue_drained", 64'(win_q.size()), 64'd0);
        chk("tag_queue_drained", 64'(tag_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; state = ST_IDLE;
        clear_stats();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_window_valid", 64'(window_valid), 64'd0);
        chk_wide("rst_window_LU", window_LU, '0);
        chk_wide("rst_window_RD", window_RD, '0);
        chk("rst_map_type", 64'(map_type), 64'd0);
        chk("rst_fmap_idx", 64'(fmap_idx), 64'd0);
        chk("rst_raddrs", {sram_raddr_0, sram_raddr_1, sram_raddr_2, sram_raddr_3}, 64'd0);
        chk("rst_delay5_addrs", {read_addr0_delay5, read_addr1_delay5, read_addr2_delay5, read_addr3_delay5}, 64'd0);
        chk("rst_delay5_tags", 64'({map_type_delay5, fmap_idx_delay5}), 64'd0);
        chk("rst_output_en", 64'(output_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        // start outside a scan state must be ignored
        @(posedge clk); #2 state = ST_PADDING; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (4) @(negedge clk);
        chk("padding_start_busy", 64'(busy), 64'd0);
        chk("padding_start_output_en", 64'(oe_cnt), 64'd0);

        // CONV1 reads A; mid-run start and state change must not disturb it
        run_scan(ST_CONV1, 1'b0, 24, 1'b1);

        // RES_1 aborted by reset during issue 10
        clear_stats();
        push_scan(1'b1, 24);
        @(posedge clk); #2 state = ST_RES_1; start = 1'b1;
        @(posedge clk); #1 start_cyc = cyc; #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_output_en", 64'(output_en), 64'd0);
        chk("abort_window_valid", 64'(window_valid), 64'd0);
        chk("abort_raddrs", {sram_raddr_0, sram_raddr_1, sram_raddr_2, sram_raddr_3}, 64'd0);
        win_q.delete();
        tag_q.delete();
        @(posedge clk); #2 rst = 1'b0;
        clear_stats();
        repeat (12) @(negedge clk);
        chk("abort_no_output_en", 64'(oe_cnt), 64'd0);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_no_window", 64'(wv_cnt), 64'd0);

        // Fresh RES_1 scan takes B data
        run_scan(ST_RES_1, 1'b1, 24, 1'b0);

        // UP_1 reads B; channel/phase count depends on the build option
        run_scan(ST_UP_1, 1'b1, K_UP, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
